// File: rtl/program_memory_loader.sv
// -----------------------------------------------------------------------------
// program_memory_loader
//
// Boot-time loader that fills the instruction memory from a byte stream and
// holds the core in reset until the program is in place. The stream carries a
// 16-bit little-endian word count N followed by 4*N little-endian instruction
// bytes. Each assembled word is written at BASE_ADDRESS + 4*index.
//
// Optional feature (macro LOADER_CHECKSUM_EN): after the last word, one extra
// byte is accepted and compared with the XOR of all data bytes. A mismatch
// ends the load in ERROR with the core still held.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   start_i         begin a load (sampled only in IDLE, DONE and ERROR)
//   rx_data_i       stream byte
//   rx_valid_i      rx_data_i valid
//   rx_ready_o      loader accepts a byte (transfer when valid && ready)
//   mem_we_o        program memory write strobe, one cycle per word
//   mem_addr_o      word-aligned byte address of the write
//   mem_wdata_o     assembled instruction word
//   cpu_hold_o      holds the core while high
//   busy_o          load in progress
//   done_o          load completed successfully
//   error_o         load rejected
//   words_loaded_o  words written in the current or last load
// -----------------------------------------------------------------------------
module program_memory_loader #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [15:0]           words_loaded_o
);

    localparam logic [15:0] DEPTH_W = 16'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    // Word index; it always equals the number of words written in this load,
    // so it also drives words_loaded_o.
    logic [15:0]             idx_q, idx_d;
    logic [1:0]              bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    // Word count as it will look once the high byte currently on the bus lands.
    logic [15:0] n_rx;
    assign n_rx = {rx_data_i, len_q[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN_LO;
                    len_d   = '0;
                    idx_d   = '0;
                    bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN_LO: begin
                if (rx_valid_i) begin
                    len_d[7:0] = rx_data_i;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid_i) begin
                    len_d[15:8] = rx_data_i;
                    if (n_rx == 16'd0 || n_rx > DEPTH_W) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    word_d[{bcnt_q, 3'b000} +: 8] = rx_data_i;
                    bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data_i;
`endif
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 16'd1;
                if (idx_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid_i) begin
                    state_d = (rx_data_i == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state and counters.
`ifdef LOADER_CHECKSUM_EN
    assign rx_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CHK);
`else
    assign rx_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA);
`endif
    assign busy_o         = rx_ready_o || (state_q == S_WRITE);
    assign mem_we_o       = (state_q == S_WRITE);
    // Address wraps modulo 2^DATA_WIDTH.
    assign mem_addr_o     = BASE_ADDRESS + {{(DATA_WIDTH-18){1'b0}}, idx_q, 2'b00};
    assign mem_wdata_o    = word_q;
    assign cpu_hold_o     = (state_q != S_DONE);
    assign done_o         = (state_q == S_DONE);
    assign error_o        = (state_q == S_ERROR);
    assign words_loaded_o = idx_q;

endmodule

// File: tb/tb_program_memory_loader.sv
module tb_program_memory_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        cpu_hold_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] words_loaded_o;

    program_memory_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_ready_o     (rx_ready_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .cpu_hold_o     (cpu_hold_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0       = 0;
    int we_count = 0;
    int pushes   = 0;
    logic [63:0] exp_q[$];   // {addr, data} of each expected write

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe pops the next expected word.
    always @(negedge clk) begin
        if (reset === 1'b0 && mem_we_o === 1'b1) begin
            logic [63:0] e;
            we_count++;
            check("ready_low_during_we", {31'b0, rx_ready_o}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'b0, mem_we_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr_o, e[63:32]);
                check("wr_data", mem_wdata_o, e[31:0]);
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_ready", {31'b0, rx_ready_o}, 32'd0);
        check("rst_we",    {31'b0, mem_we_o},   32'd0);
        check("rst_addr",  mem_addr_o,          BASE);
        check("rst_wdata", mem_wdata_o,         32'd0);
        check("rst_hold",  {31'b0, cpu_hold_o}, 32'd1);
        check("rst_busy",  {31'b0, busy_o},     32'd0);
        check("rst_done",  {31'b0, done_o},     32'd0);
        check("rst_error", {31'b0, error_o},    32'd0);
        check("rst_words", {16'b0, words_loaded_o}, 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the entering edge.
    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        c0 = cyc;
    endtask

    // gap=1: drop valid for two cycles after each byte; gap=0: keep valid high.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk);
        while (rx_ready_o !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("byte_accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        if (gap) begin
            rx_valid_i = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
        end
    endtask

    task automatic send_len(input logic [15:0] n, input bit gap);
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
    endtask

    task automatic send_words(input int nw, input int first, input logic [31:0] w [4],
                              input bit gap, output logic [7:0] cs);
        cs = 8'h00;
        for (int i = 0; i < nw; i++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b;
                b = w[i][8*k +: 8];
                cs ^= b;
                if (k == 3) begin
                    exp_q.push_back({BASE + 32'((first + i) * 4), w[i]});
                    pushes++;
                end
                send_byte(b, gap);
            end
        end
    endtask

    task automatic wait_flag(input bit want_done, output int at);
        int t = 0;
        while (((want_done ? done_o : error_o) !== 1'b1) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) check(want_done ? "done_timeout" : "error_timeout", 32'd1, 32'd0);
        at = cyc;
    endtask

    initial begin
        logic [31:0] w [4];
        logic [7:0]  cs;
        int          at;
        int          lat_add;
`ifdef LOADER_CHECKSUM_EN
        lat_add = 3;
`else
        lat_add = 2;
`endif
        reset = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
        repeat (2) @(posedge clk); #1;
        check_reset_outputs();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", {31'b0, cpu_hold_o}, 32'd1);

        // Basic two-word load with rx_valid held high: content and latency.
        w[0] = 32'h0000_0013; w[1] = 32'h0050_0093; w[2] = '0; w[3] = '0;
        do_start();
        check("lenlo_ready", {31'b0, rx_ready_o}, 32'd1);
        check("lenlo_busy",  {31'b0, busy_o},     32'd1);
        send_len(16'd2, 1'b0);
        send_words(2, 0, w, 1'b0, cs);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs, 1'b0);
`endif
        rx_valid_i = 1'b0;
        wait_flag(1'b1, at);
        check("t1_latency", 32'(at - c0), 32'(lat_add + 5 * 2));
        check("t1_done",  {31'b0, done_o},     32'd1);
        check("t1_hold",  {31'b0, cpu_hold_o}, 32'd0);
        check("t1_busy",  {31'b0, busy_o},     32'd0);
        check("t1_error", {31'b0, error_o},    32'd0);
        check("t1_words", {16'b0, words_loaded_o}, 32'd2);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // Zero length is rejected right after the high length byte.
        do_start();
        check("t2_done_drops", {31'b0, done_o},     32'd0);
        check("t2_hold",       {31'b0, cpu_hold_o}, 32'd1);
        check("t2_words_clr",  {16'b0, words_loaded_o}, 32'd0);
        send_len(16'd0, 1'b1);
        wait_flag(1'b0, at);
        check("t2_error", {31'b0, error_o},    32'd1);
        check("t2_hold2", {31'b0, cpu_hold_o}, 32'd1);
        check("t2_busy",  {31'b0, busy_o},     32'd0);
        check("t2_no_we", 32'(we_count), 32'(pushes));

        // Oversized length (33) is rejected; a valid N=1 load then succeeds.
        do_start();
        check("t3_error_drops", {31'b0, error_o}, 32'd0);
        send_len(16'd33, 1'b0);
        rx_valid_i = 1'b0;
        wait_flag(1'b0, at);
        check("t3_error", {31'b0, error_o}, 32'd1);
        check("t3_done",  {31'b0, done_o},  32'd0);
        w[0] = 32'h1234_5678;
        do_start();
        send_len(16'd1, 1'b0);
        send_words(1, 0, w, 1'b0, cs);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs, 1'b0);
`endif
        rx_valid_i = 1'b0;
        wait_flag(1'b1, at);
        check("t3_latency", 32'(at - c0), 32'(lat_add + 5));
        check("t3_words", {16'b0, words_loaded_o}, 32'd1);
        check("t3_queue", 32'(exp_q.size()), 32'd0);

        // N=3 with a 1-0-0-1 valid pattern; a start pulse mid-load is ignored.
        w[0] = 32'hDEAD_BEEF; w[1] = 32'h0000_0000; w[2] = 32'hFFFF_FFFF;
        do_start();
        send_len(16'd3, 1'b1);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("t4_busy_ignores_start", {31'b0, busy_o}, 32'd1);
        check("t4_ready_in_data",      {31'b0, rx_ready_o}, 32'd1);
        send_words(3, 0, w, 1'b1, cs);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs, 1'b1);
`endif
        wait_flag(1'b1, at);
        check("t4_done",  {31'b0, done_o}, 32'd1);
        check("t4_words", {16'b0, words_loaded_o}, 32'd3);
        check("t4_we",    32'(we_count), 32'(pushes));
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // Reset after 6 bytes of an N=2 load, then a full load.
        w[0] = 32'h4433_2211; w[1] = 32'h8877_6655;
        do_start();
        send_len(16'd2, 1'b1);
        send_words(1, 0, w, 1'b1, cs);
        check("t5_words_before_rst", {16'b0, words_loaded_o}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("t5_queue_after_rst", 32'(exp_q.size()), 32'd0);
        w[0] = 32'hCAFE_F00D; w[1] = 32'h0102_0304;
        do_start();
        send_len(16'd2, 1'b0);
        send_words(2, 0, w, 1'b0, cs);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs, 1'b0);
`endif
        rx_valid_i = 1'b0;
        wait_flag(1'b1, at);
        check("t5_latency", 32'(at - c0), 32'(lat_add + 10));
        check("t5_words", {16'b0, words_loaded_o}, 32'd2);
        check("t5_hold",  {31'b0, cpu_hold_o}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: word written, load ends in ERROR with the core held.
        w[0] = 32'h0000_0013;
        do_start();
        send_len(16'd1, 1'b0);
        send_words(1, 0, w, 1'b0, cs);
        send_byte(8'h00, 1'b0);
        rx_valid_i = 1'b0;
        wait_flag(1'b0, at);
        check("t6_error", {31'b0, error_o},    32'd1);
        check("t6_done",  {31'b0, done_o},     32'd0);
        check("t6_hold",  {31'b0, cpu_hold_o}, 32'd1);
        check("t6_words", {16'b0, words_loaded_o}, 32'd1);
`endif

        repeat (3) @(posedge clk); #1;
        check("final_we_count", 32'(we_count), 32'(pushes));
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
